sobel_window_ctrl: RTL and testbench

Streaming 3x3 window sequencer for the Sobel path. It accepts RGB444 pixels in raster order, one per valid cycle. Two line buffers plus three column shift registers assemble the 3x3 neighbourhood. Each complete window is presented as nine parallel 12-bit taps, ready to drive the per-tap grayscale conversion and the Sobel kernel. The block sits between the camera/frame-buffer read stream and the gray/Sobel datapath, and owns frame/row/column sequencing and border masking.

---
 rtl/sobel_window_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// 3x3 window sequencer: raster RGB444 in, nine border-masked taps out.
// Two line buffers feed a two-column history; the live column is the third.
module sobel_window_ctrl #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_valid,
    input  logic                      i_sof,
    input  logic [11:0]               i_pixel,
    output logic [11:0]               data00_o,
    output logic [11:0]               data01_o,
    output logic [11:0]               data02_o,
    output logic [11:0]               data10_o,
    output logic [11:0]               data11_o,
    output logic [11:0]               data12_o,
    output logic [11:0]               data20_o,
    output logic [11:0]               data21_o,
    output logic [11:0]               data22_o,
    output logic                      o_valid,
    output logic [$clog2(IMG_W)-1:0]  o_x,
    output logic [$clog2(IMG_H)-1:0]  o_y,
    output logic                      o_frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [XW-1:0]  col_q, col_d;
    logic [YW-1:0]  row_q, row_d;

    logic [11:0]    lb1_q [IMG_W];
    logic [11:0]    lb2_q [IMG_W];
    logic [11:0]    lb1_rd;
    logic [11:0]    lb2_rd;

    // Index 0 holds column c-2, index 1 holds column c-1.
    logic [11:0]    top_q [2];
    logic [11:0]    top_d [2];
    logic [11:0]    mid_q [2];
    logic [11:0]    mid_d [2];
    logic [11:0]    bot_q [2];
    logic [11:0]    bot_d [2];

    logic [11:0]    tap_q [9];
    logic [11:0]    tap_d [9];
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;

    logic           sof;
    logic           active;
    logic           acc;
    logic [XW-1:0]  cur_c;
    logic [YW-1:0]  cur_r;
    logic           col_end;
    logic           fill_end;
    logic           run_end;
    logic           emit;
    logic           mask_x;
    logic           mask_y;

    // A start-of-frame pixel is always (0,0), whatever the counters say.
    assign sof     = i_valid & i_sof;
    assign active  = (state_q == S_FILL) | (state_q == S_RUN);
    assign acc     = sof | (i_valid & active);
    assign cur_c   = sof ? '0 : col_q;
    assign cur_r   = sof ? '0 : row_q;
    assign col_end = (cur_c == X_LAST);

    assign fill_end = !sof && i_valid && (state_q == S_FILL)
                      && (col_q == X_LAST);
    assign run_end  = !sof && i_valid && (state_q == S_RUN)
                      && (col_q == X_LAST) && (row_q == Y_LAST);

    assign emit   = acc && (cur_c != '0) && (cur_r != '0);
    assign mask_x = (cur_c == X_ONE);
    assign mask_y = (cur_r == Y_ONE);

    assign lb1_rd = lb1_q[cur_c];
    assign lb2_rd = lb2_q[cur_c];

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        tap_d   = tap_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        unique case (1'b1)
            sof: begin
                state_d = S_FILL;
            end
            fill_end: begin
                state_d = S_RUN;
            end
            run_end: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: ;
        endcase

        if (acc) begin
            col_d    = col_end ? '0 : cur_c + X_ONE;
            row_d    = col_end ? cur_r + Y_ONE : cur_r;
            top_d[0] = top_q[1];
            top_d[1] = lb2_rd;
            mid_d[0] = mid_q[1];
            mid_d[1] = lb1_rd;
            bot_d[0] = bot_q[1];
            bot_d[1] = i_pixel;
        end

        // Masked taps would otherwise carry the previous row/frame.
        if (emit) begin
            valid_d  = 1'b1;
            x_d      = cur_c - X_ONE;
            y_d      = cur_r - Y_ONE;
            tap_d[0] = (mask_x | mask_y) ? '0 : top_q[0];
            tap_d[1] = mask_y ? '0 : top_q[1];
            tap_d[2] = mask_y ? '0 : lb2_rd;
            tap_d[3] = mask_x ? '0 : mid_q[0];
            tap_d[4] = mid_q[1];
            tap_d[5] = lb1_rd;
            tap_d[6] = mask_x ? '0 : bot_q[0];
            tap_d[7] = bot_q[1];
            tap_d[8] = i_pixel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                top_q[i] <= '0;
                mid_q[i] <= '0;
                bot_q[i] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            x_q     <= x_d;
            y_q     <= y_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            bot_q   <= bot_d;
            tap_q   <= tap_d;
        end
    end

    // Line buffers carry no reset; border masking hides stale lines.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb2_q[cur_c] <= lb1_rd;
            lb1_q[cur_c] <= i_pixel;
        end
    end

    assign data00_o     = tap_q[0];
    assign data01_o     = tap_q[1];
    assign data02_o     = tap_q[2];
    assign data10_o     = tap_q[3];
    assign data11_o     = tap_q[4];
    assign data12_o     = tap_q[5];
    assign data20_o     = tap_q[6];
    assign data21_o     = tap_q[7];
    assign data22_o     = tap_q[8];
    assign o_valid      = valid_q;
    assign o_x          = x_q;
    assign o_y          = y_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 4x3 frame.
// Windows are logged by a monitor and compared with hand tables.
module tb_sobel_window_ctrl;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_sof = 1'b0;
    logic [11:0] i_pixel = '0;
    logic [11:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
    logic        o_valid;
    logic [1:0]  o_x;
    logic [1:0]  o_y;
    logic        o_frame_done;

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_valid      (i_valid),
        .i_sof        (i_sof),
        .i_pixel      (i_pixel),
        .data00_o     (d00),
        .data01_o     (d01),
        .data02_o     (d02),
        .data10_o     (d10),
        .data11_o     (d11),
        .data12_o     (d12),
        .data20_o     (d20),
        .data21_o     (d21),
        .data22_o     (d22),
        .o_valid      (o_valid),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0][11:0] t;
        int               x;
        int               y;
        int               fd;
        int               cyc;
    } win_t;

    win_t mon_q[$];
    win_t exp_q[$];
    win_t mw;
    int   cyc = 0;
    int   fd_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    // Hand-computed taps for pixel = r*4+c; -1 marks a masked tap.
    int tab [6][9] = '{
        '{-1, -1, -1, -1,  0,  1, -1,  4,  5},
        '{-1, -1, -1,  0,  1,  2,  4,  5,  6},
        '{-1, -1, -1,  1,  2,  3,  5,  6,  7},
        '{-1,  0,  1, -1,  4,  5, -1,  8,  9},
        '{ 0,  1,  2,  4,  5,  6,  8,  9, 10},
        '{ 1,  2,  3,  5,  6,  7,  9, 10, 11}
    };

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (o_valid) begin
            mw.t[0] = d00; mw.t[1] = d01; mw.t[2] = d02;
            mw.t[3] = d10; mw.t[4] = d11; mw.t[5] = d12;
            mw.t[6] = d20; mw.t[7] = d21; mw.t[8] = d22;
            mw.x    = int'(o_x);
            mw.y    = int'(o_y);
            mw.fd   = int'(o_frame_done);
            mw.cyc  = cyc;
            mon_q.push_back(mw);
        end
        if (o_frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_px(input logic [11:0] px, input logic sof);
        @(negedge clk);
        i_valid = 1'b1;
        i_sof   = sof;
        i_pixel = px;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_sof   = 1'b0;
        end
    endtask

    task automatic send_frame(input int base, input int gap, input int n);
        win_t e;
        int   r, c, k;
        for (int i = 0; i < n; i++) begin
            r = i / W;
            c = i % W;
            send_px(12'(base + i), i == 0);
            if (c >= 1 && r >= 1) begin
                k = (r - 1) * (W - 1) + (c - 1);
                for (int j = 0; j < 9; j++)
                    e.t[j] = (tab[k][j] < 0) ? 12'h000 : 12'(base + tab[k][j]);
                e.x   = c - 1;
                e.y   = r - 1;
                e.fd  = (i == W * H - 1) ? 1 : 0;
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            if (gap != 0) idle(1);
        end
    endtask

    task automatic check_windows(input string nm);
        int n;
        chk({nm, "_nwin"}, mon_q.size(), exp_q.size());
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 9; j++)
                chk($sformatf("%s_w%0d_t%0d", nm, k, j),
                    int'(mon_q[k].t[j]), int'(exp_q[k].t[j]));
            chk($sformatf("%s_w%0d_x", nm, k), mon_q[k].x, exp_q[k].x);
            chk($sformatf("%s_w%0d_y", nm, k), mon_q[k].y, exp_q[k].y);
            chk($sformatf("%s_w%0d_fd", nm, k), mon_q[k].fd, exp_q[k].fd);
            chk($sformatf("%s_w%0d_cyc", nm, k), mon_q[k].cyc, exp_q[k].cyc);
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            i_valid = ~i_valid;
            i_sof   = 1'b1;
            i_pixel = 12'h5a5;
            #1;
            chk("rst_valid", o_valid, 0);
            chk("rst_fd", o_frame_done, 0);
            chk("rst_x", o_x, 0);
            chk("rst_y", o_y, 0);
            chk("rst_d11", d11, 0);
            chk("rst_d22", d22, 0);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_sof   = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) send_px(12'(i + 1), 1'b0);
        idle(3);
        chk("nosof_nwin", mon_q.size(), 0);
        mon_q.delete();

        send_frame(0, 0, W * H);
        idle(3);
        check_windows("full");
        chk("full_fdcnt", fd_cnt, 1);
        fd_cnt = 0;

        send_frame(0, 1, W * H);
        idle(3);
        check_windows("gap");
        chk("gap_fdcnt", fd_cnt, 1);
        fd_cnt = 0;

        send_frame(0, 0, 7);
        send_frame(100, 0, W * H);
        idle(3);
        check_windows("restart");
        chk("restart_fdcnt", fd_cnt, 1);
        fd_cnt = 0;

        send_frame(0, 0, W * H);
        send_frame(200, 0, W * H);
        idle(3);
        check_windows("b2b");
        chk("b2b_fdcnt", fd_cnt, 2);
        fd_cnt = 0;

        send_frame(300, 0, 7);
        idle(2);
        check_windows("pre_arst");
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_d22", d22, 0);
        chk("arst_d21", d21, 0);
        chk("arst_d11", d11, 0);
        chk("arst_x", o_x, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < W * H; i++) send_px(12'(i + 7), 1'b0);
        idle(3);
        chk("arst_idle_nwin", mon_q.size(), 0);
        chk("arst_idle_fd", fd_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
